// File: rtl/pwl_tone_sequencer.sv
// pwl_tone_sequencer: steps a PWL sin/cos source through a programmable table of tone settings.
// Ports: clk/rst (sync, active-high); cfg_* table write port (accepted only while not busy);
// num_steps/loop_en/start/abort sequence control; freq/amp/offset/ph tone outputs with
// upd strobe on every change; src_en, step_idx, busy status; done and cfg_err one-cycle pulses.
module pwl_tone_sequencer #(
  parameter int  DEPTH      = 8,
  parameter int  AW         = 3,
  parameter int  DW         = 16,
  parameter real DEF_FREQ   = 100e6,
  parameter real DEF_OFFSET = 0.0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  real           cfg_freq,
  input  real           cfg_amp,
  input  real           cfg_offset,
  input  real           cfg_ph,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [AW:0]   num_steps,
  input  logic          loop_en,
  input  logic          start,
  input  logic          abort,
  output real           freq,
  output real           amp,
  output real           offset,
  output real           ph,
  output logic          upd,
  output logic          src_en,
  output logic [AW-1:0] step_idx,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  state_t state, state_n;
  real t_freq [DEPTH];
  real t_amp  [DEPTH];
  real t_off  [DEPTH];
  real t_ph   [DEPTH];
  logic [DW-1:0] t_dw [DEPTH];
  logic [DW-1:0] cnt, cnt_n;
  real freq_n, amp_n, offset_n, ph_n;
  logic upd_n, src_en_n, busy_n, done_n;
  logic [AW-1:0] idx_n, li;
  logic [AW:0] n;
  logic last, expire, go, adv, stop, load;
  always_ff @(posedge clk)
    if (cfg_we && !busy) begin
      t_freq[cfg_addr] <= cfg_freq;
      t_amp[cfg_addr]  <= cfg_amp;
      t_off[cfg_addr]  <= cfg_offset;
      t_ph[cfg_addr]   <= cfg_ph;
      t_dw[cfg_addr]   <= cfg_dwell;
    end
  always_comb begin
    n        = num_steps > DEPTH_W ? DEPTH_W : num_steps;
    last     = {1'b0, step_idx} + (AW+1)'(1) >= n;
    // counter holds the remaining cycles of the current entry, including this one
    expire   = cnt <= DW'(1);
    go       = state == IDLE && start && n != '0;
    adv      = state == RUN && !abort && expire && (!last || loop_en);
    stop     = state == RUN && (abort || (expire && last && !loop_en));
    load     = go || adv;
    li       = (go || last) ? '0 : step_idx + AW'(1);
    state_n  = stop ? STOP : go ? RUN : state == STOP ? IDLE : state;
    freq_n   = load ? t_freq[li] : stop ? DEF_FREQ : freq;
    amp_n    = load ? t_amp[li] : stop ? 0.0 : amp;
    offset_n = load ? t_off[li] : stop ? DEF_OFFSET : offset;
    ph_n     = load ? t_ph[li] : stop ? 0.0 : ph;
    idx_n    = load ? li : step_idx;
    // a zero dwell still holds the entry for one cycle
    cnt_n    = load ? (t_dw[li] == '0 ? DW'(1) : t_dw[li]) : state == RUN ? cnt - DW'(1) : cnt;
    upd_n    = load || stop;
    src_en_n = load ? 1'b1 : stop ? 1'b0 : src_en;
    busy_n   = load ? 1'b1 : stop ? 1'b0 : busy;
    done_n   = stop && !abort;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state    <= IDLE;
      freq     <= DEF_FREQ;
      amp      <= 0.0;
      offset   <= DEF_OFFSET;
      ph       <= 0.0;
      upd      <= 1'b0;
      src_en   <= 1'b0;
      step_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      freq     <= freq_n;
      amp      <= amp_n;
      offset   <= offset_n;
      ph       <= ph_n;
      upd      <= upd_n;
      src_en   <= src_en_n;
      step_idx <= idx_n;
      busy     <= busy_n;
      done     <= done_n;
      cfg_err  <= cfg_we && busy;
      cnt      <= cnt_n;
    end
endmodule

// File: tb/tb_pwl_tone_sequencer.sv
// tb_pwl_tone_sequencer: scoreboard bench; expected strobes are queued by stimulus and popped by a monitor.
module tb_pwl_tone_sequencer;
  logic clk = 0, rst = 1, cfg_we = 0, loop_en = 0, start = 0, abort = 0;
  logic [2:0] cfg_addr = 0;
  real cfg_freq = 0, cfg_amp = 0, cfg_offset = 0, cfg_ph = 0;
  logic [15:0] cfg_dwell = 0;
  logic [3:0] num_steps = 0;
  real freq, amp, offset, ph;
  logic upd, src_en, busy, done, cfg_err;
  logic [2:0] step_idx;
  int cyc = 0, vectors = 0, miscompares = 0, b;
  typedef struct {int c; real f, a, o, p; bit en, bz, dn; int idx;} exp_t;
  exp_t q[$];
  int cq[$];
  real tf[8], ta[8], to[8], tp[8];
  pwl_tone_sequencer dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_freq(cfg_freq),
    .cfg_amp(cfg_amp), .cfg_offset(cfg_offset), .cfg_ph(cfg_ph), .cfg_dwell(cfg_dwell),
    .num_steps(num_steps), .loop_en(loop_en), .start(start), .abort(abort),
    .freq(freq), .amp(amp), .offset(offset), .ph(ph), .upd(upd), .src_en(src_en),
    .step_idx(step_idx), .busy(busy), .done(done), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d want < 10000", cyc);
    $fatal(1);
  end
  always @(negedge clk) begin
    exp_t e;
    if (upd) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL upd: unexpected strobe at cycle %0d (freq=%g amp=%g idx=%0d), want none", cyc, freq, amp, step_idx);
      end else begin
        e = q.pop_front();
        if (cyc != e.c || freq != e.f || amp != e.a || offset != e.o || ph != e.p || src_en != e.en ||
            busy != e.bz || done != e.dn || (e.idx >= 0 && int'(step_idx) != e.idx)) begin
          miscompares++;
          $display("FAIL upd: got cyc=%0d f=%g a=%g o=%g p=%g en=%b busy=%b done=%b idx=%0d, want cyc=%0d f=%g a=%g o=%g p=%g en=%b busy=%b done=%b idx=%0d",
                   cyc, freq, amp, offset, ph, src_en, busy, done, step_idx, e.c, e.f, e.a, e.o, e.p, e.en, e.bz, e.dn, e.idx);
        end
      end
    end else if (done) begin
      vectors++;
      miscompares++;
      $display("FAIL done: pulse without upd at cycle %0d, want none", cyc);
    end
    if (cfg_err) begin
      vectors++;
      if (cq.size() == 0 || cq[0] != cyc) begin
        miscompares++;
        $display("FAIL cfg_err: pulse at cycle %0d, want %0d", cyc, cq.size() ? cq[0] : -1);
      end
      if (cq.size()) void'(cq.pop_front());
    end
  end
  function automatic void push(int c, real f, real a, real o, real p, bit en, bit bz, bit dn, int idx);
    exp_t e;
    e.c = c; e.f = f; e.a = a; e.o = o; e.p = p; e.en = en; e.bz = bz; e.dn = dn; e.idx = idx;
    q.push_back(e);
  endfunction
  function automatic void push_entry(int c, int k);
    push(c, tf[k], ta[k], to[k], tp[k], 1, 1, 0, k);
  endfunction
  function automatic void push_stop(int c, bit dn);
    push(c, 100e6, 0.0, 0.0, 0.0, 0, 0, dn, -1);
  endfunction
  function automatic void shadow(int a, real f, real am, real o, real p);
    tf[a] = f; ta[a] = am; to[a] = o; tp[a] = p;
  endfunction
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_until(int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic set_cfg(int a, real f, real am, real o, real p, int d);
    cfg_addr = 3'(a); cfg_freq = f; cfg_amp = am; cfg_offset = o; cfg_ph = p; cfg_dwell = 16'(d);
  endtask
  task automatic wr(int a, real f, real am, real o, real p, int d);
    step(1);
    set_cfg(a, f, am, o, p, d);
    cfg_we = 1;
    step(1);
    cfg_we = 0;
    shadow(a, f, am, o, p);
  endtask
  task automatic go(int ns, bit lp);
    step(1);
    num_steps = 4'(ns); loop_en = lp; start = 1;
    b = cyc;
  endtask
  task automatic drain(string nm, int budget);
    for (int i = 0; i < budget && (q.size() != 0 || cq.size() != 0); i++) @(negedge clk);
    vectors++;
    if (q.size() != 0 || cq.size() != 0) begin
      miscompares++;
      $display("FAIL %s drain: got %0d strobes and %0d cfg_err still pending, want 0", nm, q.size(), cq.size());
    end
    q.delete(); cq.delete();
    step(2);
  endtask
  task automatic chk(string nm, real got, real want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %g want %g", nm, got, want);
    end
  endtask
  task automatic chk_idle(string nm);
    chk({nm, " freq"}, freq, 100e6);
    chk({nm, " amp"}, amp, 0.0);
    chk({nm, " offset"}, offset, 0.0);
    chk({nm, " ph"}, ph, 0.0);
    chk({nm, " src_en"}, src_en, 0);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " upd"}, upd, 0);
    chk({nm, " done"}, done, 0);
    chk({nm, " idx"}, step_idx, 0);
  endtask
  initial begin
    step(3);
    chk_idle("reset");
    chk("reset cfg_err", cfg_err, 0);
    rst = 0;
    wr(0, 1e6, 0.1, 0.01, 10.0, 4);
    wr(1, 2e6, 0.2, 0.02, 20.0, 4);
    wr(2, 3e6, 0.3, 0.03, 30.0, 4);
    go(3, 0);
    push_entry(b + 1, 0); push_entry(b + 5, 1); push_entry(b + 9, 2); push_stop(b + 13, 1);
    step(1); start = 0;
    drain("sweep", 30);
    chk("sweep end busy", busy, 0);
    go(3, 1);
    push_entry(b + 1, 0); push_entry(b + 5, 1); push_entry(b + 9, 2);
    push_entry(b + 13, 0); push_entry(b + 17, 1); push_stop(b + 19, 0);
    step(1); start = 0;
    wait_until(b + 3);
    set_cfg(1, 9e6, 0.9, 0.09, 90.0, 4);
    cfg_we = 1;
    cq.push_back(b + 4);
    step(1); cfg_we = 0;
    wait_until(b + 7);
    start = 1;
    step(1); start = 0;
    wait_until(b + 18);
    abort = 1;
    step(1); abort = 0;
    drain("loop abort", 30);
    chk("abort end busy", busy, 0);
    chk("abort end src_en", src_en, 0);
    wr(1, 2.5e6, 0.25, 0.025, 25.0, 1);
    wr(0, 5e6, 0.5, 0.05, 50.0, 0);
    wr(2, 7e6, 0.7, 0.07, 70.0, 2);
    go(3, 0);
    push_entry(b + 1, 0); push_entry(b + 2, 1); push_entry(b + 3, 2); push_stop(b + 5, 1);
    set_cfg(0, 6e6, 0.6, 0.06, 60.0, 3);
    cfg_we = 1; abort = 1;
    step(1); start = 0; cfg_we = 0; abort = 0;
    shadow(0, 6e6, 0.6, 0.06, 60.0);
    drain("dwell", 20);
    go(0, 0);
    step(1); start = 0;
    step(3);
    chk("ns0 busy", busy, 0);
    chk("ns0 src_en", src_en, 0);
    go(3, 0);
    push_entry(b + 1, 0); push_entry(b + 4, 1);
    step(1); start = 0;
    wait_until(b + 4);
    chk("pre-reset idx", step_idx, 1);
    rst = 1;
    step(1); rst = 0;
    chk_idle("mid-run reset");
    drain("reset", 2);
    go(3, 0);
    push_entry(b + 1, 0); push_entry(b + 4, 1); push_entry(b + 5, 2); push_stop(b + 7, 1);
    step(1); start = 0;
    drain("replay", 20);
    for (int k = 0; k < 8; k++) wr(k, (k + 1) * 1e6, 0.05 * (k + 1), 0.0, 5.0 * k, 1);
    go(15, 0);
    for (int k = 0; k < 8; k++) push_entry(b + 1 + k, k);
    push_stop(b + 9, 1);
    step(1); start = 0;
    drain("clamp", 30);
    chk("clamp end busy", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
